// File: rtl/scope_pkg.sv
// rtl/scope_pkg.sv - shared ADC width and pattern mode encodings
package scope_pkg;

  localparam int ADC_DATA_W = 8;

  localparam logic [1:0] MODE_RAMP   = 2'd0;
  localparam logic [1:0] MODE_TRI    = 2'd1;
  localparam logic [1:0] MODE_SQUARE = 2'd2;
  localparam logic [1:0] MODE_CONST  = 2'd3;

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - multi-flop synchroniser with a one-cycle rising-edge pulse
module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/adc_emulator.sv
// rtl/adc_emulator.sv - pipelined 8-bit parallel ADC stand-in driven by the scope's ADC clock
module adc_emulator
  import scope_pkg::*;
#(
  parameter int DATA_W      = ADC_DATA_W,
  parameter int PIPE_LAT    = 3,
  parameter int SQ_HALF     = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iADC_CLK,
  input  logic              iADC_nOE,
  input  logic [1:0]        iMODE,
  input  logic [DATA_W-1:0] iCONST,
  output logic [DATA_W-1:0] oADC_Byte,
  output logic              oADC_DRIVE,
  output logic              oSTROBE
);

  localparam int SQ_W = (SQ_HALF > 1) ? $clog2(SQ_HALF) : 1;
  localparam logic [DATA_W-1:0] ONE    = DATA_W'(1);
  localparam logic [SQ_W-1:0]   SQ_ONE = SQ_W'(1);
  localparam logic [SQ_W-1:0]   SQ_END = SQ_W'(SQ_HALF - 1);

  logic tick;

  edge_sync #(.STAGES(SYNC_STAGES)) u_clk_sync (
    .clk   (iCLK),
    .rst_n (iRST_N),
    .din   (iADC_CLK),
    .rise  (tick)
  );

  logic [SYNC_STAGES-1:0] noe_sync_q;
  logic [1:0]             mode_q;
  logic [DATA_W-1:0]      cnt_q;
  logic                   dir_down_q;
  logic                   sq_phase_q;
  logic [SQ_W-1:0]        sq_cnt_q;
  logic [DATA_W-1:0]      pipe_q [PIPE_LAT];
  logic [DATA_W-1:0]      out_q;
  logic                   drive_q;
  logic                   strobe_q;

  logic                   restart;
  logic [DATA_W-1:0]      base_cnt;
  logic                   base_down;
  logic                   base_phase;
  logic [SQ_W-1:0]        base_sq;
  logic [DATA_W-1:0]      gen;
  logic [DATA_W-1:0]      cnt_d;
  logic                   dir_down_d;
  logic                   sq_phase_d;
  logic [SQ_W-1:0]        sq_cnt_d;

  // A mode change restarts the generator so the new pattern starts at phase 0 on this tick.
  always_comb begin
    restart    = (iMODE != mode_q);
    base_cnt   = restart ? '0 : cnt_q;
    base_down  = restart ? 1'b0 : dir_down_q;
    base_phase = restart ? 1'b0 : sq_phase_q;
    base_sq    = restart ? '0 : sq_cnt_q;
    gen        = '0;
    cnt_d      = base_cnt;
    dir_down_d = base_down;
    sq_phase_d = base_phase;
    sq_cnt_d   = base_sq;
    case (iMODE)
      MODE_RAMP: begin
        gen   = base_cnt;
        cnt_d = base_cnt + ONE;
      end
      MODE_TRI: begin
        gen = base_cnt;
        if (!base_down) begin
          if (base_cnt == '1) begin
            dir_down_d = 1'b1;
            cnt_d      = base_cnt - ONE;
          end else begin
            cnt_d = base_cnt + ONE;
          end
        end else begin
          if (base_cnt == '0) begin
            dir_down_d = 1'b0;
            cnt_d      = base_cnt + ONE;
          end else begin
            cnt_d = base_cnt - ONE;
          end
        end
      end
      MODE_SQUARE: begin
        gen = base_phase ? '1 : '0;
        if (base_sq == SQ_END) begin
          sq_cnt_d   = '0;
          sq_phase_d = ~base_phase;
        end else begin
          sq_cnt_d = base_sq + SQ_ONE;
        end
      end
      default: gen = iCONST;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      noe_sync_q <= '0;
      mode_q     <= MODE_RAMP;
      cnt_q      <= '0;
      dir_down_q <= 1'b0;
      sq_phase_q <= 1'b0;
      sq_cnt_q   <= '0;
      pipe_q     <= '{default: '0};
      out_q      <= '0;
      drive_q    <= 1'b0;
      strobe_q   <= 1'b0;
    end else begin
      noe_sync_q <= {noe_sync_q[SYNC_STAGES-2:0], iADC_nOE};
      drive_q    <= ~noe_sync_q[SYNC_STAGES-1];
      strobe_q   <= tick;
      if (tick) begin
        mode_q     <= iMODE;
        cnt_q      <= cnt_d;
        dir_down_q <= dir_down_d;
        sq_phase_q <= sq_phase_d;
        sq_cnt_q   <= sq_cnt_d;
        pipe_q[0]  <= gen;
        for (int k = 1; k < PIPE_LAT; k++) pipe_q[k] <= pipe_q[k-1];
        out_q      <= pipe_q[PIPE_LAT-1];
      end
    end
  end

  assign oADC_Byte  = drive_q ? out_q : '0;
  assign oADC_DRIVE = drive_q;
  assign oSTROBE    = strobe_q;

endmodule

// File: tb/tb_adc_emulator.sv
// tb/tb_adc_emulator.sv - directed and table-driven checks of the ADC emulator
module tb_adc_emulator;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b1;
  logic       iADC_CLK = 1'b0;
  logic       iADC_nOE = 1'b0;
  logic [1:0] iMODE = 2'd0;
  logic [7:0] iCONST = 8'h00;
  logic [7:0] oADC_Byte;
  logic       oADC_DRIVE;
  logic       oSTROBE;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] cval;
    logic       noe;
    logic [7:0] exp_byte;
    logic       exp_drive;
  } vec_t;

  vec_t tbl [35];

  adc_emulator #(
    .DATA_W      (8),
    .PIPE_LAT    (3),
    .SQ_HALF     (4),
    .SYNC_STAGES (2)
  ) dut (
    .iCLK       (iCLK),
    .iRST_N     (iRST_N),
    .iADC_CLK   (iADC_CLK),
    .iADC_nOE   (iADC_nOE),
    .iMODE      (iMODE),
    .iCONST     (iCONST),
    .oADC_Byte  (oADC_Byte),
    .oADC_DRIVE (oADC_DRIVE),
    .oSTROBE    (oSTROBE)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One ADC clock period of 8 iCLK cycles; the strobe must appear exactly 3 cycles after the pin rises.
  task automatic adc_edge();
    int scnt = 0;
    int spos = -1;
    @(negedge iCLK);
    iADC_CLK = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      if (i == 5) begin
        @(negedge iCLK);
        iADC_CLK = 1'b0;
      end
      @(posedge iCLK);
      #1;
      if (oSTROBE) begin
        scnt++;
        spos = i;
      end
    end
    chk("strobe_count", scnt, 1);
    chk("strobe_latency", spos, 3);
  endtask

  task automatic do_reset();
    @(negedge iCLK);
    iRST_N = 1'b0;
    #1;
    chk("rst_byte", int'(oADC_Byte), 0);
    chk("rst_drive", int'(oADC_DRIVE), 0);
    chk("rst_strobe", int'(oSTROBE), 0);
    @(negedge iCLK);
    @(negedge iCLK);
    iRST_N = 1'b1;
  endtask

  function automatic int tri_val(input int j);
    int p;
    p = j % 510;
    return (p <= 255) ? p : 510 - p;
  endfunction

  initial begin
    int n;
    int sc;

    // Mode change, const drain, restart of ramp, then output-enable gating.
    for (int e = 1; e <= 35; e++) begin
      tbl[e-1].mode      = 2'd0;
      tbl[e-1].cval      = 8'hA5;
      tbl[e-1].noe       = 1'b0;
      tbl[e-1].exp_drive = 1'b1;
      if (e <= 17)      tbl[e-1].exp_byte = (e < 4) ? 8'h00 : 8'(e - 4);
      else if (e <= 25) tbl[e-1].exp_byte = 8'hA5;
      else              tbl[e-1].exp_byte = 8'(e - 26);
      if (e >= 15 && e <= 22) tbl[e-1].mode = 2'd3;
      if (e >= 28 && e <= 32) begin
        tbl[e-1].noe       = 1'b1;
        tbl[e-1].exp_byte  = 8'h00;
        tbl[e-1].exp_drive = 1'b0;
      end
    end

    do_reset();

    iMODE = 2'd0;
    for (int e = 1; e <= 300; e++) begin
      adc_edge();
      n = (e < 4) ? 0 : ((e - 4) % 256);
      chk($sformatf("ramp_e%0d", e), int'(oADC_Byte), n);
    end
    chk("ramp_drive", int'(oADC_DRIVE), 1);

    sc = 0;
    repeat (50) begin
      @(posedge iCLK);
      #1;
      if (oSTROBE) sc++;
    end
    chk("stall_strobe", sc, 0);
    chk("stall_byte", int'(oADC_Byte), 40);

    do_reset();
    iMODE = 2'd1;
    for (int e = 1; e <= 600; e++) begin
      adc_edge();
      n = (e < 4) ? 0 : tri_val(e - 4);
      chk($sformatf("tri_e%0d", e), int'(oADC_Byte), n);
    end

    do_reset();
    iMODE = 2'd2;
    for (int e = 1; e <= 40; e++) begin
      adc_edge();
      n = (e < 4) ? 0 : ((((e - 4) / 4) % 2 == 1) ? 255 : 0);
      chk($sformatf("sq_e%0d", e), int'(oADC_Byte), n);
    end

    do_reset();
    for (int i = 0; i < 35; i++) begin
      iMODE    = tbl[i].mode;
      iCONST   = tbl[i].cval;
      iADC_nOE = tbl[i].noe;
      adc_edge();
      chk($sformatf("tbl_byte_%0d", i + 1), int'(oADC_Byte), int'(tbl[i].exp_byte));
      chk($sformatf("tbl_drive_%0d", i + 1), int'(oADC_DRIVE), int'(tbl[i].exp_drive));
    end

    do_reset();
    iMODE = 2'd0;
    iADC_nOE = 1'b0;
    for (int e = 1; e <= 68; e++) adc_edge();
    chk("pre_reset_byte", int'(oADC_Byte), 8'h40);
    do_reset();
    for (int e = 1; e <= 6; e++) begin
      adc_edge();
      n = (e < 4) ? 0 : e - 4;
      chk($sformatf("post_reset_e%0d", e), int'(oADC_Byte), n);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
